a_rom_reader: RTL and testbench

//  Read-side sequencer for the packed A-matrix ROM (8x4 matrix, 7-bit elements, two per 14-bit word,

---
 rtl/a_rom_reader.sv | 171 +++++++++++++++++
 tb/tb_a_rom_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_rom_reader.sv
// Read-side sequencer for the packed A-matrix ROM.
// Walks every ROM word in column-major order, splits each word into its high (even row) and
// low (odd row) element, and streams the elements over a valid/ready interface. The next word
// is captured in the same cycle the low element is accepted, so a continuous consumer sees one
// element per cycle with no bubbles between words.
module a_rom_reader #(
    parameter int unsigned ELEM_W = 7,
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic [ADDR_W-1:0]     rom_addr_o,
    input  logic [2*ELEM_W-1:0]   a_input_i,
    output logic [ELEM_W-1:0]     elem_data_o,
    output logic [2:0]            elem_row_o,
    output logic [1:0]            elem_col_o,
    output logic                  elem_last_o,
    output logic                  elem_valid_o,
    input  logic                  elem_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned PairsPerCol = ROWS / 2;
    localparam int unsigned NumWords    = PairsPerCol * COLS;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StEmitHi,
        StEmitLo,
        StDone
    } state_e;

    state_e                state_q;
    logic [ADDR_W-1:0]     rom_addr_q;
    logic [ADDR_W-1:0]     word_idx_q;
    logic [2*ELEM_W-1:0]   word_q;
    logic [ELEM_W-1:0]     elem_data_q;
    logic [2:0]            elem_row_q;
    logic [1:0]            elem_col_q;
    logic                  elem_last_q;
    logic                  elem_valid_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  is_last_word;

    // Row of an element: the high half carries the even row of its pair, the low half the odd row.
    function automatic logic [2:0] row_of(input logic [ADDR_W-1:0] w, input logic lo);
        return 3'((int'(w) % PairsPerCol) * 2 + int'(lo));
    endfunction

    function automatic logic [1:0] col_of(input logic [ADDR_W-1:0] w);
        return 2'(int'(w) / PairsPerCol);
    endfunction

    // Decode of the final word of the matrix.
    always_comb begin
        is_last_word = (word_idx_q == ADDR_W'(NumWords - 1));
    end

    // Sequencer FSM; every output is registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            rom_addr_q   <= '0;
            word_idx_q   <= '0;
            word_q       <= '0;
            elem_data_q  <= '0;
            elem_row_q   <= '0;
            elem_col_q   <= '0;
            elem_last_q  <= 1'b0;
            elem_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (abort_i) begin
            // Abort beats everything, including a simultaneous start.
            state_q      <= StIdle;
            rom_addr_q   <= '0;
            word_idx_q   <= '0;
            word_q       <= '0;
            elem_data_q  <= '0;
            elem_row_q   <= '0;
            elem_col_q   <= '0;
            elem_last_q  <= 1'b0;
            elem_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q    <= StFetch;
                        rom_addr_q <= '0;
                        word_idx_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                StFetch: begin
                    // ROM registers address 0 on this edge.
                    state_q <= StLatch;
                end
                StLatch: begin
                    word_q       <= a_input_i;
                    rom_addr_q   <= rom_addr_q + ADDR_W'(1);
                    elem_data_q  <= a_input_i[2*ELEM_W-1:ELEM_W];
                    elem_row_q   <= row_of(word_idx_q, 1'b0);
                    elem_col_q   <= col_of(word_idx_q);
                    elem_last_q  <= 1'b0;
                    elem_valid_q <= 1'b1;
                    state_q      <= StEmitHi;
                end
                StEmitHi: begin
                    if (elem_ready_i) begin
                        elem_data_q <= word_q[ELEM_W-1:0];
                        elem_row_q  <= row_of(word_idx_q, 1'b1);
                        elem_last_q <= is_last_word;
                        state_q     <= StEmitLo;
                    end
                end
                StEmitLo: begin
                    if (elem_ready_i) begin
                        if (!is_last_word) begin
                            // ROM already holds the next word since rom_addr moved on entering HI.
                            word_q      <= a_input_i;
                            rom_addr_q  <= rom_addr_q + ADDR_W'(1);
                            word_idx_q  <= word_idx_q + ADDR_W'(1);
                            elem_data_q <= a_input_i[2*ELEM_W-1:ELEM_W];
                            elem_row_q  <= row_of(word_idx_q + ADDR_W'(1), 1'b0);
                            elem_col_q  <= col_of(word_idx_q + ADDR_W'(1));
                            elem_last_q <= 1'b0;
                            state_q     <= StEmitHi;
                        end else begin
                            elem_valid_q <= 1'b0;
                            elem_data_q  <= '0;
                            elem_row_q   <= '0;
                            elem_col_q   <= '0;
                            elem_last_q  <= 1'b0;
                            done_q       <= 1'b1;
                            state_q      <= StDone;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rom_addr_o   = rom_addr_q;
    assign elem_data_o  = elem_data_q;
    assign elem_row_o   = elem_row_q;
    assign elem_col_o   = elem_col_q;
    assign elem_last_o  = elem_last_q;
    assign elem_valid_o = elem_valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_a_rom_reader.sv
// Bench for a_rom_reader: table of whole-stream scenarios checked against an element list
// derived directly from the ROM contents, plus hand-written stall, abort and reset sequences.
module tb_a_rom_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  rom_addr;
    logic [13:0] a_input = '0;
    logic [6:0]  elem_data;
    logic [2:0]  elem_row;
    logic [1:0]  elem_col;
    logic        elem_last;
    logic        elem_valid;
    logic        elem_ready;
    logic        busy;
    logic        done;

    logic [13:0] mem [16];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int ready_mode;   // 0 always ready, 1 toggling, 2 random
        bit rand_rom;
        bit poke_start;
        int lo;
        int hi;
    } vec_t;

    vec_t tbl [6];

    a_rom_reader dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .rom_addr_o   (rom_addr),
        .a_input_i    (a_input),
        .elem_data_o  (elem_data),
        .elem_row_o   (elem_row),
        .elem_col_o   (elem_col),
        .elem_last_o  (elem_last),
        .elem_valid_o (elem_valid),
        .elem_ready_i (elem_ready),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    // 1-cycle registered ROM
    always @(posedge clk) a_input <= mem[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_rom(input bit rnd);
        for (int w = 0; w < 16; w++) begin
            int c = w / 4;
            int p = w % 4;
            if (rnd) mem[w] = 14'($urandom);
            else if (c == 0) mem[w] = {7'(2 * p + 1), 7'(2 * p + 2)};
            else mem[w] = {7'd1, 7'd1};
        end
    endtask

    function automatic logic [12:0] cur_elem();
        return {elem_data, elem_row, elem_col, elem_last};
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full stream with checks of order, hold-under-stall, latency and done timing.
    task automatic run_stream(input int mode, input bit poke, input int lo, input int hi);
        logic [12:0] exp_q [$];
        logic [12:0] held = '0;
        bit stalled = 0;
        int idx = 0;
        int k = 0;
        int first_k = -1;
        int done_k = -1;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 8; r++) begin
                logic [13:0] wd = mem[c * 4 + r / 2];
                logic [6:0] d = (r % 2 == 0) ? wd[13:7] : wd[6:0];
                exp_q.push_back({d, 3'(r), 2'(c), (r == 7 && c == 3)});
            end
        end
        pulse_start();
        while (done_k < 0 && k < 3000) begin
            if (elem_valid) begin
                if (first_k < 0) first_k = k;
                if (stalled) check("hold", 32'(cur_elem()), 32'(held));
            end else begin
                if (stalled) check("valid_dropped", 32'(elem_valid), 32'd1);
                check("idle_zero", {26'd0, elem_row, elem_col, elem_last}, 32'd0);
            end
            if (done) begin
                done_k = k;
                check("busy_in_done", 32'(busy), 32'd1);
                check("elem_count", idx, 32);
            end
            case (mode)
                0: elem_ready = 1'b1;
                1: elem_ready = k[0];
                default: elem_ready = ($urandom_range(0, 99) < 70);
            endcase
            start = poke && (k == 10 || done);
            if (elem_valid && elem_ready) begin
                if (idx < 32) check("elem", 32'(cur_elem()), 32'(exp_q[idx]));
                else check("extra_elem", idx, 31);
                idx++;
                stalled = 0;
            end else if (elem_valid) begin
                stalled = 1;
                held = cur_elem();
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (done_k < 0) check("done_timeout", 0, 1);
        check("latency", first_k, 2);
        check("done_window", 32'(done_k >= lo && done_k <= hi), 32'd1);
        check("post_done", {29'd0, busy, done, elem_valid}, 32'd0);
        if (poke) begin
            repeat (3) @(negedge clk);
            check("start_ignored", {30'd0, busy, elem_valid}, 32'd0);
        end
        elem_ready = 1'b1;
    endtask

    // Wait (bounded) for the n-th offered element with ready held high; returns at a negedge.
    task automatic wait_elem(input int n, output bit ok);
        int idx = 0;
        ok = 0;
        elem_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (elem_valid) begin
                if (idx == n) begin
                    ok = 1;
                    return;
                end
                idx++;
            end
        end
    endtask

    task automatic drain();
        bit seen = 0;
        elem_ready = 1'b1;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("drain_done", 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        int done_seen;
        tbl[0] = '{ready_mode: 0, rand_rom: 0, poke_start: 0, lo: 34, hi: 34};
        tbl[1] = '{ready_mode: 1, rand_rom: 0, poke_start: 0, lo: 65, hi: 67};
        tbl[2] = '{ready_mode: 0, rand_rom: 0, poke_start: 1, lo: 34, hi: 34};
        tbl[3] = '{ready_mode: 2, rand_rom: 1, poke_start: 0, lo: 34, hi: 600};
        tbl[4] = '{ready_mode: 2, rand_rom: 1, poke_start: 0, lo: 34, hi: 600};
        tbl[5] = '{ready_mode: 0, rand_rom: 1, poke_start: 0, lo: 34, hi: 34};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        elem_ready = 1'b0;
        load_rom(0);
        #12;
        check("reset_outs", {rom_addr, elem_data, elem_row, elem_col, elem_last, elem_valid,
                             busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", {30'd0, busy, elem_valid}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            load_rom(tbl[i].rand_rom);
            run_stream(tbl[i].ready_mode, tbl[i].poke_start, tbl[i].lo, tbl[i].hi);
        end

        // Long stall on the low element of word 3.
        load_rom(0);
        pulse_start();
        wait_elem(7, ok);
        check("stall_reach", 32'(ok), 32'd1);
        elem_ready = 1'b0;
        for (int t = 0; t < 10; t++) begin
            check("stall_addr", 32'(rom_addr), 32'd4);
            check("stall_data", {24'd0, elem_valid, elem_data}, {24'd0, 1'b1, 7'd8});
            @(negedge clk);
        end
        elem_ready = 1'b1;
        @(negedge clk);
        check("after_stall", {20'd0, elem_valid, elem_data, elem_row, elem_col},
              {20'd0, 1'b1, 7'd1, 3'd0, 2'd1});
        drain();

        // Abort at the 13th element, then restart.
        pulse_start();
        wait_elem(12, ok);
        check("abort_reach", 32'(ok), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_state", {22'd0, rom_addr, elem_valid, busy, done, elem_last}, 32'd0);
        done_seen = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (done || busy || elem_valid) done_seen++;
        end
        check("abort_quiet", done_seen, 0);
        run_stream(0, 0, 34, 34);

        // Start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", 32'(busy), 32'd0);

        // Asynchronous reset during a high element.
        pulse_start();
        wait_elem(4, ok);
        check("rst_reach", {30'd0, ok, elem_row[0]}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {rom_addr, elem_data, elem_row, elem_col, elem_last, elem_valid,
                              busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (done || busy || elem_valid || rom_addr != 0) done_seen++;
        end
        check("stay_idle", done_seen, 0);
        run_stream(0, 0, 34, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
